// File: rtl/tff_bank_pkg.sv
// Shared definitions for the T-FF bank counter: mode encodings and the
// carry-chain helper used to build up/down toggle vectors.
package tff_bank_pkg;

  localparam logic [1:0] MODE_TGL = 2'b00;
  localparam logic [1:0] MODE_UP  = 2'b01;
  localparam logic [1:0] MODE_DN  = 2'b10;
  localparam logic [1:0] MODE_LD  = 2'b11;

  localparam int unsigned CHAIN_MAX = 64;

  // Toggle bit idx of a binary counter: every lower bit is 1 (up) or 0 (down).
  function automatic logic chain_bit(input logic [CHAIN_MAX-1:0] q,
                                     input int unsigned idx,
                                     input logic dn);
    logic r;
    r = 1'b1;
    for (int unsigned k = 0; k < CHAIN_MAX; k++) begin
      if (k < idx) begin
        r = r & (q[k] ^ dn);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tff_bank_counter_cell.sv
// One-bit toggle flip-flop with synchronous active-high reset and enable.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic t,
  output logic q
);

  // State bit: reset value, toggle when enabled, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (en) begin
      q <= q ^ t;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/tff_bank_counter.sv
// WIDTH-bit toggle bank / up-down counter with load built on tff_cell.
// Optional modulo wrap point enabled by defining TFF_BANK_MODULO_EN.
module tff_bank_counter
  import tff_bank_pkg::*;
#(
  parameter int unsigned          WIDTH    = 8,
  parameter int unsigned          SATURATE = 0,
  parameter logic [WIDTH-1:0]     RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_in,
  input  logic [WIDTH-1:0] load_val,
`ifdef TFF_BANK_MODULO_EN
  input  logic [WIDTH-1:0] modulus,
`endif
  output logic [WIDTH-1:0] q,
  output logic             ovf
);

  logic [CHAIN_MAX-1:0] q_ext_s;
  logic [WIDTH-1:0]     up_tv_s;
  logic [WIDTH-1:0]     dn_tv_s;
  logic [WIDTH-1:0]     tv_s;
  logic [WIDTH-1:0]     max_s;
  logic                 up_end_s;
  logic                 dn_end_s;
  logic                 ovf_next_s;

  assign q_ext_s = CHAIN_MAX'(q);

`ifdef TFF_BANK_MODULO_EN
  // Values above the modulus (reached by load or toggle) also wrap/clamp.
  assign max_s    = modulus;
  assign up_end_s = (q >= modulus);
`else
  assign max_s    = '1;
  assign up_end_s = &q;
`endif
  assign dn_end_s = ~|q;

  // Toggle-vector selection; wraps and clamps force tv = q ^ target.
  always_comb begin
    tv_s       = '0;
    ovf_next_s = 1'b0;
    case (mode)
      MODE_TGL: begin
        tv_s = t_in;
      end
      MODE_UP: begin
        if (up_end_s) begin
          ovf_next_s = 1'b1;
          if (SATURATE != 0) begin
            tv_s = q ^ max_s;
          end else begin
            tv_s = q;
          end
        end else begin
          tv_s = up_tv_s;
        end
      end
      MODE_DN: begin
        if (dn_end_s) begin
          ovf_next_s = 1'b1;
          if (SATURATE != 0) begin
            tv_s = '0;
          end else begin
            tv_s = q ^ max_s;
          end
        end else begin
          tv_s = dn_tv_s;
        end
      end
      MODE_LD: begin
        tv_s = q ^ load_val;
      end
      default: begin
        tv_s = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign up_tv_s[i] = chain_bit(q_ext_s, i, 1'b0);
    assign dn_tv_s[i] = chain_bit(q_ext_s, i, 1'b1);

    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[i]),
      .en      (en),
      .t       (tv_s[i]),
      .q       (q[i])
    );
  end

  // Overflow pulse register, cleared by reset or a disabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (!en) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf_next_s;
    end
  end

endmodule

// File: doc/tff_bank_counter.md
Name: tff_bank_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit register built from per-bit T-FF cells.
- Operates either as a raw toggle bank (each bit toggles on its own T input) or as a synchronous up/down counter with parallel load.
- Every state change goes through a per-bit toggle vector, so all modes share one cell array.
- Used wherever the design needs toggle registers, event counters or divide-by-N timers.

Parameters:
- WIDTH, 8, number of bits / T-FF cells (>=1).
- SATURATE, 0, when 1 the counter clamps at its end values instead of wrapping.
- RST_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock, only clock in the block.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; 0 = hold all bits.
- mode  input  2  00 toggle-bank, 01 count up, 10 count down, 11 parallel load.
- t_in  input  WIDTH  per-bit toggle requests (mode 00 only).
- load_val  input  WIDTH  value for mode 11.
- q  output  WIDTH  registered state.
- ovf  output  1  registered one-cycle pulse on wrap or clamp attempt.

Behaviour:
- Reset and priority:
  - All updates occur on posedge clk.
  - Priority is rst > !en > mode.
  - rst=1 -> q=RST_VAL, ovf=0 on that edge, regardless of en, mode or any count in progress; the following cycle operates normally.
- Hold: en=0 -> q holds, ovf=0.
- Per-bit toggle vector tv[WIDTH-1:0]: q_next[i] = q[i] ^ tv[i], implemented by the tff_cell array.
  - mode 00: tv = t_in; ovf=0.
  - mode 01: tv[0]=1, tv[i]=&q[i-1:0]; at q = MAX, next q = 0 and ovf=1.
  - mode 10: tv[0]=1, tv[i]=&~q[i-1:0]; at q = 0, next q = MAX and ovf=1.
  - mode 11: tv = q ^ load_val (q_next = load_val); ovf=0.
- MAX = 2^WIDTH-1 (or the modulus when the optional feature is compiled in).
- SATURATE=1:
  - mode 01 at q=MAX -> tv=0, q holds MAX, ovf=1 (pulses every enabled cycle while clamped).
  - mode 10 at q=0 -> q holds 0, ovf=1.
- ovf is registered: high for exactly the cycle after the wrapping edge, then cleared unless another wrap or clamp occurs.
- Latency: one cycle from inputs to q/ovf; there is no combinational path from inputs to outputs.
- Mode changes take effect on the next edge; there is no pipeline state.
- WIDTH=1: up and down both toggle q; ovf=1 whenever q goes 1->0 (up) or 0->1 (down).

Optional Feature:
- Macro TFF_BANK_MODULO_EN.
- When defined:
  - Adds input modulus [WIDTH-1:0] and sets MAX = modulus.
  - Up mode: q==modulus -> 0, ovf=1.
  - Up mode with q>modulus (reachable via load or toggle) -> 0, ovf=1.
  - Down mode: q==0 -> modulus, ovf=1.
  - Under SATURATE, q clamps at modulus instead.
  - Implemented by forcing tv = q ^ target on wrap.
- When undefined: no modulus port; MAX = all-ones; no comparator logic.

Decomposition:
- Shared package tff_bank_pkg:
  - mode encodings: MODE_TGL=2'b00, MODE_UP=2'b01, MODE_DN=2'b10, MODE_LD=2'b11.
  - function computing the up/down carry-chain toggle vector.
- Sub-module tff_cell:
  - One-bit T-FF with synchronous active-high rst, rst value input and enable.
  - Instantiated WIDTH times via generate.
- Top module holds the toggle-vector mux, ovf register and optional modulo compare.

Test Plan:
- WIDTH=4, rst=1 for 2 cycles with en=1, mode=01 -> q=0, ovf=0 throughout reset; release -> q=1,2,3… each cycle.
- mode=00, q=4'b0000, t_in=4'b1010 for 2 enabled cycles -> q=1010 then 0000, ovf=0.
- mode=01 from q=4'hE -> q=F, then 0 with ovf=1 for exactly one cycle, then 1 with ovf=0.
- mode=10 from q=1 -> 0, then F with ovf=1.
- SATURATE=1: same run reaches 0 and stays 0 with ovf=1 each cycle.
- mode=11 load_val=4'h9 with en=0 -> no change; en=1 -> q=9. Then rst=1 mid-count at q=7 -> q=RST_VAL next edge.
- TFF_BANK_MODULO_EN, modulus=5, up from 0 -> 0..5,0 with ovf on the 5->0 edge. Load 9 then up -> 0 with ovf=1. Down from 0 -> 5.
